// File: rtl/mem_arb_1i1d.sv
// Two-requester memory arbiter: round-robin request grant with a stall lock,
// and in-order response routing driven by a FIFO of issuing-port IDs.
//
// state    | meaning
// ST_OPEN  | no stalled request; grant follows the priority pointer
// ST_LOCK0 | port 0 request stalled downstream; grant pinned to port 0
// ST_LOCK1 | port 1 request stalled downstream; grant pinned to port 1
module mem_arb_1i1d #(
  parameter int p_nbits        = 32,
  parameter int p_max_inflight = 4,
  localparam int REQW  = p_nbits + $clog2(p_nbits/8) + 44,
  localparam int RESPW = p_nbits + $clog2(p_nbits/8) + 14,
  localparam int PW    = $clog2(p_max_inflight),
  localparam int IW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic [REQW-1:0]  req0_msg,
  output logic             resp0_val,
  input  logic             resp0_rdy,
  output logic [RESPW-1:0] resp0_msg,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic [REQW-1:0]  req1_msg,
  output logic             resp1_val,
  input  logic             resp1_rdy,
  output logic [RESPW-1:0] resp1_msg,
  output logic             memreq_val,
  input  logic             memreq_rdy,
  output logic [REQW-1:0]  memreq_msg,
  input  logic             memresp_val,
  output logic             memresp_rdy,
  input  logic [RESPW-1:0] memresp_msg,
  output logic [IW-1:0]    inflight
);

  typedef enum logic [1:0] {
    ST_OPEN  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } lock_e;

  lock_e          state_q, state_d;
  logic           prio_q, prio_d;
  logic           ids_q [p_max_inflight];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [IW-1:0]  cnt_q;

  logic [1:0] req_val;
  logic       gnt, gnt_any;
  logic       full, empty, head;
  logic       push, pop;

  assign req_val = {req1_val, req0_val};
  assign full    = (cnt_q == IW'(p_max_inflight));
  assign empty   = (cnt_q == '0);
  assign head    = ids_q[rptr_q];

  always_comb begin
    gnt     = 1'b0;
    gnt_any = 1'b0;
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      ST_LOCK0: begin
        gnt     = 1'b0;
        gnt_any = 1'b1;
      end
      ST_LOCK1: begin
        gnt     = 1'b1;
        gnt_any = 1'b1;
      end
      default: begin
        if (req_val[prio_q]) begin
          gnt     = prio_q;
          gnt_any = 1'b1;
        end else if (req_val[~prio_q]) begin
          gnt     = ~prio_q;
          gnt_any = 1'b1;
        end
      end
    endcase

    memreq_val = gnt_any & req_val[gnt] & ~full;
    memreq_msg = (gnt_any & gnt) ? req1_msg : req0_msg;
    req0_rdy   = gnt_any & ~gnt & memreq_rdy & ~full;
    req1_rdy   = gnt_any &  gnt & memreq_rdy & ~full;
    push       = memreq_val & memreq_rdy;

    // A stalled request pins the grant until it is accepted.
    if (push) begin
      state_d = ST_OPEN;
      prio_d  = ~gnt;
    end else if (memreq_val) begin
      state_d = gnt ? ST_LOCK1 : ST_LOCK0;
    end
  end

  // Response side depends only on registered FIFO state, never on memreq_*.
  assign resp0_val   = memresp_val & ~empty & ~head;
  assign resp1_val   = memresp_val & ~empty &  head;
  assign memresp_rdy = ~empty & (head ? resp1_rdy : resp0_rdy);
  assign pop         = memresp_val & memresp_rdy;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign inflight    = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OPEN;
      prio_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + IW'(push) - IW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ids_q[wptr_q] <= gnt;
  end

endmodule

// File: doc/mem_arb_1i1d.md
MEM_ARB_1I1D -- requirements
Module: mem_arb_1i1d

Interface
REQ-001 The block SHALL have parameter p_nbits, default 32, the data-field width in bits of all request and response messages (multiple of 8, at least 8).
REQ-002 The block SHALL have parameter p_max_inflight, default 4, the maximum number of outstanding downstream requests (power of 2, at least 2).
REQ-003 The block SHALL define REQW = p_nbits+$clog2(p_nbits/8)+44 and RESPW = p_nbits+$clog2(p_nbits/8)+14.
REQ-004 Request fields SHALL be, MSB to LSB: type(4), opaque(8), addr(32), len, data; response fields SHALL be type(4), opaque(8), test(2), len, data.
REQ-005 Ports SHALL be:
clk  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high reset
req0_val  in  1  requester 0 (instruction side) request valid
req0_rdy  out  1  requester 0 request ready
req0_msg  in  REQW  requester 0 request message
resp0_val  out  1  requester 0 response valid
resp0_rdy  in  1  requester 0 response ready
resp0_msg  out  RESPW  requester 0 response message
req1_val/req1_rdy/req1_msg, resp1_val/resp1_rdy/resp1_msg  same directions and widths as port 0, requester 1 (data side)
memreq_val  out  1  downstream request valid
memreq_rdy  in  1  downstream request ready
memreq_msg  out  REQW  downstream request message
memresp_val  in  1  downstream response valid
memresp_rdy  out  1  downstream response ready
memresp_msg  in  RESPW  downstream response message
inflight  out  $clog2(p_max_inflight)+1  count of outstanding downstream requests

Function
REQ-006 A transfer on any val/rdy pair SHALL occur on a rising clk edge at which both val and rdy are 1.
REQ-007 The block SHALL keep a 1-bit priority pointer prio; while unlocked, grant = prio if req[prio]_val is 1, else the other port if its val is 1, else none.
REQ-008 memreq_val SHALL equal val of the granted port AND NOT full, where full means inflight == p_max_inflight.
REQ-009 memreq_msg SHALL equal the granted port's req msg, unmodified; when there is no grant it SHALL equal req0_msg.
REQ-010 reqN_rdy SHALL be 1 only when N is granted AND memreq_rdy AND NOT full; the non-granted port's rdy SHALL be 0.
REQ-011 Lock: after a cycle in which memreq_val=1 without a transfer, the grant SHALL stay on the same port until that port's transfer completes, even if the other port has higher priority.
REQ-012 On each downstream request transfer, prio SHALL become the port not granted, and the lock SHALL clear.
REQ-013 The block SHALL hold a FIFO of 1-bit port IDs, depth p_max_inflight; it SHALL push the granted ID on each memreq transfer and pop on each memresp transfer.
REQ-014 Downstream responses SHALL be taken to return in request order; the FIFO head SHALL select the destination port.
REQ-015 respN_val SHALL equal memresp_val AND NOT empty AND (head == N); the other port's resp_val SHALL be 0.
REQ-016 resp0_msg and resp1_msg SHALL both equal memresp_msg, passed through unmodified with zero latency.
REQ-017 memresp_rdy SHALL equal NOT empty AND resp[head]_rdy; when the FIFO is empty, memresp_rdy SHALL be 0 and memresp_val SHALL be ignored.
REQ-018 inflight SHALL update each cycle as inflight + push - pop.
REQ-019 Simultaneous push and pop SHALL leave inflight unchanged.
REQ-020 When full, push SHALL be blocked even if a pop occurs in the same cycle (no full bypass).
REQ-021 A pop and a push in the same cycle on an empty FIFO SHALL NOT occur, because REQ-017 forbids the pop.
REQ-022 FIFO read and write pointers SHALL wrap modulo p_max_inflight.
REQ-023 The request path SHALL have zero-cycle combinational latency; the response path SHALL have zero-cycle combinational latency.
REQ-024 The block SHALL create no combinational path from memresp_* to memreq_*.

Reset
REQ-025 While reset=1 at a clk edge, the block SHALL set prio to 0, clear the lock, empty the FIFO and set the pointers and inflight to 0.
REQ-026 During and after reset, memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val and memresp_rdy SHALL be 0 until inputs are applied.
REQ-027 A reset mid-operation SHALL discard all outstanding IDs; later stray memresp_val SHALL be ignored because of REQ-017.

Verification
REQ-028 Simultaneous requests after reset: req0_val=req1_val=1, memreq_rdy=1 -> port 0 transfers in cycle 1 and port 1 in cycle 2; memreq_msg matches each source in turn.
REQ-029 Lock under backpressure: req1_val=1 only, memreq_rdy=0 for 3 cycles, then req0_val rises with memreq_rdy=1 -> port 1 transfers first, and req1_msg stays on memreq_msg throughout the stall.
REQ-030 Full: p_max_inflight=4, 4 transfers with no response -> inflight=4 and memreq_val=0; one memresp transfer -> inflight=3 and the next request is accepted the following cycle.
REQ-031 Routing: issue IDs 0,1,1,0, return 4 responses with opaque 0xA0..0xA3 -> they are delivered to resp0, resp1, resp1, resp0 in that order with unchanged msgs.
REQ-032 Response backpressure: head=1, resp1_rdy=0, resp0_rdy=1 -> memresp_rdy=0, resp0_val=0 and inflight is held.
REQ-033 Reset with 2 outstanding requests -> inflight=0; a memresp_val=1 afterward -> memresp_rdy=0 and both resp_val=0.
